// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes,
// FSM state constants and small decode helpers.
package e_mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [0:0] MDU_IDLE = 1'b0;
    localparam logic [0:0] MDU_RUN  = 1'b1;

    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return is_mult(op) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Execute-stage bus between the pipeline datapath and the multiply/divide unit.
interface e_mdu_if;
    logic [3:0]  E_MDUOp;
    logic        E_start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_busy;
    logic [31:0] E_MDUout;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    modport master (
        output E_MDUOp, E_start, E_A, E_B,
        input  E_busy, E_MDUout, E_HI, E_LO
    );

    modport slave (
        input  E_MDUOp, E_start, E_A, E_B,
        output E_busy, E_MDUout, E_HI, E_LO
    );
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath working on the latched operands;
// yields {hi,lo} and flags a zero divisor so the wrapper can skip the write.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        a_neg_s     = 1'b0;
        b_neg_s     = 1'b0;
        a_mag_s     = a;
        b_mag_s     = b;
        q_mag_s     = 32'd0;
        r_mag_s     = 32'd0;
        case (op)
            OP_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULTU: result = {32'd0, a} * {32'd0, b};
            OP_DIV, OP_DIVU: begin
                if (op == OP_DIV) begin
                    a_neg_s = a[31];
                    b_neg_s = b[31];
                end else begin
                    a_neg_s = 1'b0;
                    b_neg_s = 1'b0;
                end
                a_mag_s = neg_if(a, a_neg_s);
                b_mag_s = neg_if(b, b_neg_s);
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    q_mag_s = a_mag_s / b_mag_s;
                    r_mag_s = a_mag_s % b_mag_s;
                end
                result = {neg_if(r_mag_s, a_neg_s), neg_if(q_mag_s, a_neg_s ^ b_neg_s)};
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO ownership, fixed-latency mult/div
// sequencing and mfhi/mflo/mthi/mtlo handling.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave bus
);

    logic [0:0]  state_r;
    logic [7:0]  count_r;
    logic        busy_r;
    logic [3:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] result_s;
    logic        dbz_s;
    logic        launch_s;
    logic [31:0] mduout_s;

    e_mdu_calc u_calc (
        .op          (op_r),
        .a           (a_r),
        .b           (b_r),
        .result      (result_s),
        .div_by_zero (dbz_s)
    );

    assign launch_s = bus.E_start && is_muldiv(bus.E_MDUOp);

    // Sequencer: launch, countdown, HI/LO commit and move-to writes while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MDU_IDLE;
            count_r <= 8'd0;
            busy_r  <= 1'b0;
            op_r    <= OP_NONE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    if (launch_s) begin
                        state_r <= MDU_RUN;
                        busy_r  <= 1'b1;
                        op_r    <= bus.E_MDUOp;
                        a_r     <= bus.E_A;
                        b_r     <= bus.E_B;
                        count_r <= is_mult(bus.E_MDUOp) ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
                    end else if (bus.E_MDUOp == OP_MTHI) begin
                        hi_r <= bus.E_A;
                    end else if (bus.E_MDUOp == OP_MTLO) begin
                        lo_r <= bus.E_A;
                    end
                end
                MDU_RUN: begin
                    if (count_r <= 8'd1) begin
                        state_r <= MDU_IDLE;
                        busy_r  <= 1'b0;
                        count_r <= 8'd0;
                        if (!dbz_s) begin
                            hi_r <= result_s[63:32];
                            lo_r <= result_s[31:0];
                        end
                    end else begin
                        count_r <= count_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= MDU_IDLE;
                    busy_r  <= 1'b0;
                    count_r <= 8'd0;
                end
            endcase
        end
    end

    // Read mux is deliberately combinational so mfhi/mflo reach E_AR in the same cycle.
    always_comb begin
        mduout_s = 32'd0;
        case (bus.E_MDUOp)
            OP_MFHI: mduout_s = hi_r;
            OP_MFLO: mduout_s = lo_r;
            default: mduout_s = 32'd0;
        endcase
    end

    assign bus.E_busy   = busy_r;
    assign bus.E_MDUout = mduout_s;
    assign bus.E_HI     = hi_r;
    assign bus.E_LO     = lo_r;

endmodule
